multi_alarm_ctrl: RTL and testbench

Parametrised successor of the single-alarm block. Holds N_ALARMS independent HH:MM alarms, each settable and individually enabled, plus snooze with a limit and an auto-stop ring timeout. It sits between time_mem and the display path. It consumes the BCD current time, the debounced button pulses and the 1 Hz clock. It exports the selected alarm for display and drives the ring LED sequence.

---
 rtl/alarm_pkg.sv | 25 ++
 rtl/alarm_slot.sv | 34 +++
 rtl/multi_alarm_ctrl.sv | 173 +++++++++++++++++
 tb/tb_multi_alarm_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and BCD helper for the multi-alarm controller
package alarm_pkg;

  typedef struct packed {
    logic [3:0] h_tens;
    logic [3:0] h_ones;
    logic [3:0] m_tens;
    logic [3:0] m_ones;
  } bcd_hm_t;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} alm_state_e;

  // Two-digit BCD increment that wraps to 00 once value reaches max
  function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] value, input logic [7:0] max);
    logic [7:0] r;
    if (value == max)
      r = 8'h00;
    else if (value[3:0] == 4'd9)
      r = {value[7:4] + 4'd1, 4'd0};
    else
      r = {value[7:4], value[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/alarm_slot.sv
// rtl/alarm_slot.sv - one HH:MM alarm slot with enable flag and match comparator
module alarm_slot
  import alarm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        edit_en,
  input  logic        add_hour,
  input  logic        add_minute,
  input  logic        toggle,
  input  logic        match_en,
  input  logic [23:0] current_time,
  output bcd_hm_t     hm,
  output logic        enabled,
  output logic        match
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hm      <= '0;
      enabled <= 1'b0;
    end else begin
      if (edit_en && add_hour)
        {hm.h_tens, hm.h_ones} <= bcd_inc_wrap({hm.h_tens, hm.h_ones}, 8'h23);
      if (edit_en && add_minute)
        {hm.m_tens, hm.m_ones} <= bcd_inc_wrap({hm.m_tens, hm.m_ones}, 8'h59);
      if (toggle)
        enabled <= ~enabled;
    end
  end

  assign match = match_en && enabled && (current_time == {hm, 8'h00});

endmodule

// File: rtl/multi_alarm_ctrl.sv
// rtl/multi_alarm_ctrl.sv - N-slot alarm controller with snooze limit and ring timeout
module multi_alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int N_ALARMS       = 4,
  parameter int N_LEDS         = 7,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZE     = 3,
  localparam int SEL_W         = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_1s,
  input  logic [23:0]         current_time,
  input  logic                config_en,
  input  logic [SEL_W-1:0]    alm_sel,
  input  logic                add_hour_pulse,
  input  logic                add_minute_pulse,
  input  logic                toggle_en_pulse,
  input  logic                snooze_pulse,
  input  logic                stop_pulse,
  output logic [23:0]         alm_time,
  output logic [N_ALARMS-1:0] alm_enabled,
  output logic                ringing,
  output logic                snoozed,
  output logic [SEL_W-1:0]    ring_idx,
  output logic [N_LEDS-1:0]   led_seq_out
);

  localparam int RC_W = $clog2(RING_TIMEOUT_S + 1);
  localparam int NC_W = $clog2(SNOOZE_S + 1);
  localparam int SC_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  logic                clk_1s_q, clk_1s_qq, cfg_q;
  logic                tick, cfg_rise;
  bcd_hm_t             slot_hm [N_ALARMS];
  logic [N_ALARMS-1:0] slot_match;
  logic                any_match;
  logic [SEL_W-1:0]    win_idx;

  alm_state_e       state, state_n;
  logic [RC_W-1:0]  ring_cnt, ring_cnt_n;
  logic [NC_W-1:0]  nap_cnt, nap_cnt_n;
  logic [SC_W-1:0]  snooze_cnt, snooze_cnt_n;
  logic [SEL_W-1:0] ring_idx_n;
  logic [N_LEDS-1:0] led_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_1s_q  <= 1'b0;
      clk_1s_qq <= 1'b0;
      cfg_q     <= 1'b0;
    end else begin
      clk_1s_q  <= clk_1s;
      clk_1s_qq <= clk_1s_q;
      cfg_q     <= config_en;
    end
  end

  assign tick     = clk_1s_q & ~clk_1s_qq;
  assign cfg_rise = config_en & ~cfg_q;

  for (genvar i = 0; i < N_ALARMS; i++) begin : g_slot
    alarm_slot u_slot (
      .clk          (clk),
      .rst          (rst),
      .edit_en      (config_en && (alm_sel == SEL_W'(i))),
      .add_hour     (add_hour_pulse),
      .add_minute   (add_minute_pulse),
      .toggle       (toggle_en_pulse && (alm_sel == SEL_W'(i))),
      .match_en     (tick && !config_en),
      .current_time (current_time),
      .hm           (slot_hm[i]),
      .enabled      (alm_enabled[i]),
      .match        (slot_match[i])
    );
  end

  always_comb begin
    alm_time = '0;
    if (int'(alm_sel) < N_ALARMS)
      alm_time = {slot_hm[alm_sel], 8'h00};
  end

  // Scan downward so the lowest matching index is the one left standing
  always_comb begin
    any_match = 1'b0;
    win_idx   = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (slot_match[i]) begin
        any_match = 1'b1;
        win_idx   = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ring_cnt    <= '0;
      nap_cnt     <= '0;
      snooze_cnt  <= '0;
      ring_idx    <= '0;
      led_seq_out <= '0;
    end else begin
      state       <= state_n;
      ring_cnt    <= ring_cnt_n;
      nap_cnt     <= nap_cnt_n;
      snooze_cnt  <= snooze_cnt_n;
      ring_idx    <= ring_idx_n;
      led_seq_out <= led_n;
    end
  end

  always_comb begin
    state_n      = state;
    ring_cnt_n   = ring_cnt;
    nap_cnt_n    = nap_cnt;
    snooze_cnt_n = snooze_cnt;
    ring_idx_n   = ring_idx;
    led_n        = led_seq_out;
    unique case (state)
      IDLE: begin
        if (any_match) begin
          state_n      = RINGING;
          ring_idx_n   = win_idx;
          ring_cnt_n   = '0;
          snooze_cnt_n = '0;
          led_n        = N_LEDS'(1);
        end
      end
      RINGING: begin
        if (cfg_rise || stop_pulse || !alm_enabled[ring_idx]) begin
          state_n = IDLE;
        end else if (snooze_pulse) begin
          if (snooze_cnt < SC_W'(MAX_SNOOZE)) begin
            state_n      = SNOOZED;
            snooze_cnt_n = snooze_cnt + 1'b1;
            nap_cnt_n    = '0;
          end else begin
            state_n = IDLE;
          end
        end else if (tick) begin
          ring_cnt_n = ring_cnt + 1'b1;
          led_n      = (led_seq_out << 1) | (led_seq_out >> (N_LEDS - 1));
          if (ring_cnt_n == RC_W'(RING_TIMEOUT_S))
            state_n = IDLE;
        end
      end
      SNOOZED: begin
        if (cfg_rise || stop_pulse || !alm_enabled[ring_idx]) begin
          state_n = IDLE;
        end else if (tick) begin
          nap_cnt_n = nap_cnt + 1'b1;
          if (nap_cnt_n == NC_W'(SNOOZE_S)) begin
            state_n    = RINGING;
            ring_cnt_n = '0;
            led_n      = N_LEDS'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // LED bar is only lit while actually ringing
    if (state_n != RINGING)
      led_n = '0;
  end

  assign ringing = (state == RINGING);
  assign snoozed = (state == SNOOZED);

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// tb/tb_multi_alarm_ctrl.sv - directed scoreboard bench for multi_alarm_ctrl
module tb_multi_alarm_ctrl;

  localparam logic [4:0] P_HR = 5'b10000;
  localparam logic [4:0] P_MN = 5'b01000;
  localparam logic [4:0] P_TG = 5'b00100;
  localparam logic [4:0] P_SN = 5'b00010;
  localparam logic [4:0] P_ST = 5'b00001;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_1s;
  logic [23:0] current_time;
  logic        config_en;
  logic [1:0]  alm_sel;
  logic        add_hour_pulse, add_minute_pulse, toggle_en_pulse, snooze_pulse, stop_pulse;
  logic [23:0] alm_time;
  logic [3:0]  alm_enabled;
  logic        ringing, snoozed;
  logic [1:0]  ring_idx;
  logic [6:0]  led_seq_out;

  always #5 clk = ~clk;

  multi_alarm_ctrl #(
    .N_ALARMS(4), .N_LEDS(7), .RING_TIMEOUT_S(5), .SNOOZE_S(3), .MAX_SNOOZE(2)
  ) dut (
    .clk(clk), .rst(rst), .clk_1s(clk_1s), .current_time(current_time),
    .config_en(config_en), .alm_sel(alm_sel),
    .add_hour_pulse(add_hour_pulse), .add_minute_pulse(add_minute_pulse),
    .toggle_en_pulse(toggle_en_pulse), .snooze_pulse(snooze_pulse), .stop_pulse(stop_pulse),
    .alm_time(alm_time), .alm_enabled(alm_enabled), .ringing(ringing), .snoozed(snoozed),
    .ring_idx(ring_idx), .led_seq_out(led_seq_out)
  );

  logic [38:0] exp_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad = 0;

  function automatic logic [38:0] snap(input logic [23:0] t, input logic [3:0] en,
                                       input logic r, input logic s,
                                       input logic [1:0] idx, input logic [6:0] led);
    return {t, en, r, s, idx, led};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [4:0] p, input int n);
    repeat (n) begin
      {add_hour_pulse, add_minute_pulse, toggle_en_pulse, snooze_pulse, stop_pulse} = p;
      cyc(1);
      {add_hour_pulse, add_minute_pulse, toggle_en_pulse, snooze_pulse, stop_pulse} = 5'b0;
      cyc(1);
    end
  endtask

  task automatic do_tick(input int n);
    repeat (n) begin
      clk_1s = 1'b1;
      cyc(4);
      clk_1s = 1'b0;
      cyc(4);
    end
  endtask

  task automatic push(input string tag, input logic [38:0] e);
    tag_q.push_back(tag);
    exp_q.push_back(e);
  endtask

  task automatic check();
    logic [38:0] obs, e;
    string       tag;
    obs = snap(alm_time, alm_enabled, ringing, snoozed, ring_idx, led_seq_out);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; clk_1s = 1'b0; current_time = 24'h0; config_en = 1'b0; alm_sel = 2'd0;
    {add_hour_pulse, add_minute_pulse, toggle_en_pulse, snooze_pulse, stop_pulse} = 5'b0;
    push("reset", snap(24'h0, 4'b0000, 0, 0, 2'd0, 7'h00));
    cyc(3);
    rst = 1'b0;
    cyc(1);
    check();

    config_en = 1'b1; alm_sel = 2'd2;
    push("set_0730", snap(24'h073000, 4'b0100, 0, 0, 2'd0, 7'h00));
    pulse(P_HR, 7); pulse(P_MN, 30); pulse(P_TG, 1);
    check();
    push("hour_23", snap(24'h233000, 4'b0100, 0, 0, 2'd0, 7'h00));
    pulse(P_HR, 16); check();
    push("hour_wrap", snap(24'h003000, 4'b0100, 0, 0, 2'd0, 7'h00));
    pulse(P_HR, 1); check();
    push("hour_back", snap(24'h073000, 4'b0100, 0, 0, 2'd0, 7'h00));
    pulse(P_HR, 7); check();
    push("min_59", snap(24'h075900, 4'b0100, 0, 0, 2'd0, 7'h00));
    pulse(P_MN, 29); check();
    push("min_wrap", snap(24'h070000, 4'b0100, 0, 0, 2'd0, 7'h00));
    pulse(P_MN, 1); check();
    push("min_back", snap(24'h073000, 4'b0100, 0, 0, 2'd0, 7'h00));
    pulse(P_MN, 30); check();

    config_en = 1'b0; current_time = 24'h073000;
    push("ring_start", snap(24'h073000, 4'b0100, 1, 0, 2'd2, 7'h01));
    do_tick(1); current_time = 24'h073001; check();
    push("ring_rotate", snap(24'h073000, 4'b0100, 1, 0, 2'd2, 7'h10));
    do_tick(4); check();
    push("ring_timeout", snap(24'h073000, 4'b0100, 0, 0, 2'd2, 7'h00));
    do_tick(1); check();

    config_en = 1'b1; alm_sel = 2'd1;
    pulse(P_HR, 6); pulse(P_TG, 1);
    alm_sel = 2'd3;
    push("cfg_slots_1_3", snap(24'h060000, 4'b1110, 0, 0, 2'd2, 7'h00));
    pulse(P_HR, 6); pulse(P_TG, 1); check();
    config_en = 1'b0; cyc(1); current_time = 24'h060000;
    push("tie_lowest", snap(24'h060000, 4'b1110, 1, 0, 2'd1, 7'h01));
    do_tick(1); current_time = 24'h060001; check();

    push("snooze_1", snap(24'h060000, 4'b1110, 0, 1, 2'd1, 7'h00));
    pulse(P_SN, 1); check();
    push("nap_2", snap(24'h060000, 4'b1110, 0, 1, 2'd1, 7'h00));
    do_tick(2); check();
    push("rering_1", snap(24'h060000, 4'b1110, 1, 0, 2'd1, 7'h01));
    do_tick(1); check();
    push("snooze_2", snap(24'h060000, 4'b1110, 0, 1, 2'd1, 7'h00));
    pulse(P_SN, 1); check();
    push("rering_2", snap(24'h060000, 4'b1110, 1, 0, 2'd1, 7'h01));
    do_tick(3); check();
    push("snooze_limit", snap(24'h060000, 4'b1110, 0, 0, 2'd1, 7'h00));
    pulse(P_SN, 1); check();

    current_time = 24'h060000;
    push("ring_again", snap(24'h060000, 4'b1110, 1, 0, 2'd1, 7'h01));
    do_tick(1); current_time = 24'h060001; check();
    push("stop_beats_snooze", snap(24'h060000, 4'b1110, 0, 0, 2'd1, 7'h00));
    pulse(P_SN | P_ST, 1); check();
    current_time = 24'h060000;
    push("ring_for_cfg", snap(24'h060000, 4'b1110, 1, 0, 2'd1, 7'h01));
    do_tick(1); current_time = 24'h060001; check();
    push("snooze_for_cfg", snap(24'h060000, 4'b1110, 0, 1, 2'd1, 7'h00));
    pulse(P_SN, 1); check();
    push("cfg_rise_idle", snap(24'h060000, 4'b1110, 0, 0, 2'd1, 7'h00));
    config_en = 1'b1; cyc(1); check();
    config_en = 1'b0; cyc(1);

    current_time = 24'h060000;
    push("ring_for_disable", snap(24'h060000, 4'b1110, 1, 0, 2'd1, 7'h01));
    do_tick(1); current_time = 24'h060001; check();
    alm_sel = 2'd1;
    push("disable_ringing", snap(24'h060000, 4'b1100, 0, 0, 2'd1, 7'h00));
    pulse(P_TG, 1); check();

    current_time = 24'h060000;
    push("ring_slot3", snap(24'h060000, 4'b1100, 1, 0, 2'd3, 7'h01));
    do_tick(1); current_time = 24'h060001; check();
    push("async_reset", snap(24'h0, 4'b0000, 0, 0, 2'd0, 7'h00));
    @(posedge clk); #3; rst = 1'b1; #1; check();
    cyc(2); rst = 1'b0; cyc(1);
    current_time = 24'h000000; alm_sel = 2'd0;
    push("disabled_no_ring", snap(24'h0, 4'b0000, 0, 0, 2'd0, 7'h00));
    do_tick(1); check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
